// File: rtl/common_pkg.sv
// Shared types for the EX stage: ALU op encoding, divide sequencer state
// and the divide-family decode helpers.
package common_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE, BUSY, DONE
    } seq_state_t;

    function automatic logic is_div_op(input alu_op_t op);
        return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_signed_div(input alu_op_t op);
        return op inside {ALU_DIV, ALU_REM};
    endfunction

    function automatic logic is_rem_op(input alu_op_t op);
        return op inside {ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor, keep the difference if it did not underflow.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_in, quo_in[XLEN-1]};
    assign diff    = shifted - {1'b0, divisor};
    // rem_in < divisor, so a non-negative difference always fits in XLEN bits
    assign rem_out = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_out = {quo_in[XLEN-2:0], ~diff[XLEN]};

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle divide/remainder sequencer for the EX stage. Stalls the front
// of the pipe while a 32-step restoring division runs, then pulses result_valid.
module muldiv_sequencer #(
    parameter int XLEN = common_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  common_pkg::alu_op_t  alu_op,
    input  logic [XLEN-1:0]      operand_a,
    input  logic [XLEN-1:0]      operand_b,
    input  logic                 flush,
    output logic                 stall,
    output logic                 result_valid,
    output logic [XLEN-1:0]      result
);
    import common_pkg::*;

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    seq_state_t      state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [XLEN-1:0] rem_q, quo_q, div_q, result_q;
    logic            qneg_q, rneg_q, want_rem_q, bypass_q;

    logic            accept, sgn, a_neg, b_neg, div0, ovf;
    logic [XLEN-1:0] abs_a, abs_b, step_rem, step_quo, q_fix, r_fix, sel;

    assign sgn    = is_signed_div(alu_op);
    assign a_neg  = sgn & operand_a[XLEN-1];
    assign b_neg  = sgn & operand_b[XLEN-1];
    assign abs_a  = a_neg ? -operand_a : operand_a;
    assign abs_b  = b_neg ? -operand_b : operand_b;
    assign div0   = (operand_b == '0);
    assign ovf    = sgn & (operand_a == INT_MIN) & (operand_b == '1);
    assign accept = (state_q == IDLE) & start & ~flush & is_div_op(alu_op);

    div_step #(.XLEN(XLEN)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (div_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                stall   = 1'b1;
                state_d = (div0 | ovf) ? DONE : BUSY;
            end
            BUSY: begin
                stall = 1'b1;
                if (flush)
                    state_d = IDLE;
                else if (cnt_q == CW'(XLEN-1))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Short-circuit cases already hold their final values, so skip the fix-up
    assign q_fix        = qneg_q ? -quo_q : quo_q;
    assign r_fix        = rneg_q ? -rem_q : rem_q;
    assign sel          = bypass_q ? (want_rem_q ? rem_q : quo_q)
                                   : (want_rem_q ? r_fix : q_fix);
    assign result_valid = (state_q == DONE) & ~flush;
    assign result       = result_valid ? sel : result_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            result_q   <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            want_rem_q <= 1'b0;
            bypass_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                cnt_q      <= '0;
                div_q      <= abs_b;
                qneg_q     <= a_neg ^ b_neg;
                rneg_q     <= a_neg;
                want_rem_q <= is_rem_op(alu_op);
                bypass_q   <= div0 | ovf;
                if (div0) begin
                    quo_q <= '1;
                    rem_q <= operand_a;
                end else if (ovf) begin
                    quo_q <= INT_MIN;
                    rem_q <= '0;
                end else begin
                    quo_q <= abs_a;
                    rem_q <= '0;
                end
            end else if (state_q == BUSY && !flush) begin
                rem_q <= step_rem;
                quo_q <= step_quo;
                cnt_q <= cnt_q + CW'(1);
            end
            if (result_valid)
                result_q <= sel;
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected result and
// cycle, a negedge monitor pops on every result_valid pulse.
module tb_muldiv_sequencer;
    import common_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, start, flush;
    alu_op_t     alu_op;
    logic [31:0] operand_a, operand_b;
    logic        stall, result_valid;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .flush        (flush),
        .stall        (stall),
        .result_valid (result_valid),
        .result       (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got pulse result=%h at cycle %0d want none", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, " result"}, result, mon_e.res);
                chk({mon_e.name, " cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    // Start in cycle c0, expect result_valid in cycle c0+lat, stall high lat cycles
    task automatic run_op(input alu_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input int lat, input string name);
        int c0, n;
        @(posedge clk); #1;
        alu_op = op; operand_a = a; operand_b = b; start = 1'b1;
        c0 = cyc;
        sb.push_back('{expv, c0 + lat, name});
        #1;
        chk({name, " stall_accept"}, {31'b0, stall}, 32'd1);
        n = 1;
        @(posedge clk); #1;
        start = 1'b0;
        while (stall && n < 100) begin
            n++;
            @(posedge clk); #1;
        end
        chk({name, " stall_cycles"}, n, lat);
        @(posedge clk); #1;
        chk({name, " hold"}, result, expv);
    endtask

    task automatic watch_quiet(input string name, input int ncyc);
        int pulses = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            if (result_valid) pulses++;
        end
        chk(name, pulses, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        alu_op = ALU_ADD; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset valid", {31'b0, result_valid}, 32'd0);
        chk("reset result", result, 32'd0);
        reset_n = 1'b1;

        run_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu_100_7");
        run_op(ALU_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_100_7");
        run_op(ALU_DIV, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33, "div_m20_3");
        run_op(ALU_REM, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33, "rem_m20_3");
        run_op(ALU_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33, "div_20_m3");
        run_op(ALU_REM, 32'hFFFF_FFEC, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 33, "rem_m20_m3");
        run_op(ALU_DIVU, 32'd7, 32'd100, 32'd0, 33, "divu_7_100");
        run_op(ALU_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu_max_1");
        run_op(ALU_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, "divu_min_m1");
        run_op(ALU_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
        run_op(ALU_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
        run_op(ALU_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1, "rem_m5_0");
        run_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
        run_op(ALU_REMU, 32'd100, 32'd7, 32'd2, 33, "remu_before_flush");

        // flush at cycle 10 of a DIVU abandons it
        @(posedge clk); #1;
        alu_op = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        chk("flush busy_before", {31'b0, stall}, 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush stall_dropped", {31'b0, stall}, 32'd0);
        alu_op = ALU_ADD; start = 1'b1;
        #1;
        chk("add_not_accepted stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("add_not_accepted idle", {31'b0, stall}, 32'd0);
        watch_quiet("flush no_valid", 40);
        chk("flush result_hold", result, 32'd2);

        // flush in IDLE blocks the accept
        alu_op = ALU_DIVU; start = 1'b1; flush = 1'b1;
        #1;
        chk("idle_flush stall", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("idle_flush not_busy", {31'b0, stall}, 32'd0);
        watch_quiet("idle_flush no_valid", 40);

        // reset in the middle of BUSY
        alu_op = ALU_DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) begin @(posedge clk); #1; end
        chk("rst_mid busy_before", {31'b0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid stall", {31'b0, stall}, 32'd0);
        chk("rst_mid valid", {31'b0, result_valid}, 32'd0);
        chk("rst_mid result", result, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        watch_quiet("rst_mid no_valid", 40);
        run_op(ALU_DIVU, 32'd1000, 32'd10, 32'd100, 33, "divu_after_rst");

        repeat (3) @(posedge clk);
        chk("scoreboard drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 -- sole clock, rising edge.
REQ-002 SHALL have port reset_n, input, 1 -- asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 -- EX-stage instruction valid for sequencing.
REQ-004 SHALL have port alu_op, input, alu_op_t -- operation from the control word; only ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU are sequenced.
REQ-005 SHALL have port operand_a, input, 32 -- dividend (rs1).
REQ-006 SHALL have port operand_b, input, 32 -- divisor (rs2).
REQ-007 SHALL have port flush, input, 1 -- pipeline flush (branch/jump taken).
REQ-008 SHALL have port stall, output, 1 -- freezes IF/ID/EX while the operation is in flight.
REQ-009 SHALL have port result_valid, output, 1 -- one-cycle pulse, result ready.
REQ-010 SHALL have port result, output, 32 -- quotient or remainder per latched op.
REQ-011 SHALL have parameter XLEN, default 32 -- operand width; bench uses 32 only.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 IDLE: accept = start and alu_op is a divide-family op; other ops SHALL be ignored.
REQ-014 On accept, SHALL latch op, sign flags, |a|, |b| (signed ops only; unsigned ops take the raw values) and go to BUSY; iteration counter = 0.
REQ-015 stall SHALL be combinationally high in IDLE during accept and high throughout BUSY; low in DONE and idle IDLE.
REQ-016 BUSY: one restoring-division step per cycle, 32 steps; after step 32 SHALL go to DONE.
REQ-017 Normal latency: accept edge at cycle 0, result_valid high in cycle 33, exactly one cycle.
REQ-018 DONE SHALL drive result_valid=1 and the selected result, then always return to IDLE; start in DONE SHALL be ignored.
REQ-019 Signed fix-up: quotient negated when operand signs differ; remainder takes the dividend's sign.
REQ-020 Divide-by-zero (b==0): SHALL skip BUSY, go to DONE next cycle; quotient=32'hFFFF_FFFF, remainder=operand_a.
REQ-021 Signed overflow (DIV/REM, a=32'h8000_0000, b=32'hFFFF_FFFF): SHALL skip BUSY; quotient=32'h8000_0000, remainder=0.
REQ-022 Short-circuit latency: result_valid in cycle 1 after accept; stall high only in accept cycle.
REQ-023 flush in BUSY or DONE SHALL force IDLE next edge, suppress result_valid, drop stall; flush in IDLE SHALL block accept that cycle.
REQ-024 result SHALL hold its last value when result_valid=0.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, counter=0, stall=0, result_valid=0, result=0, all internal registers=0.
REQ-026 Reset asserted mid-BUSY SHALL abandon the operation; no result_valid after release until a new accept.

Structure
REQ-027 Divide-family op decode helper, FSM state enum and XLEN constant SHALL live in common_pkg; alu_op_t reused unchanged.
REQ-028 One sub-module, div_step (combinational single restoring step: remainder, quotient in -> out), SHALL be instantiated; FSM, counter and sign fix-up stay in muldiv_sequencer.
REQ-029 The ALU SHALL NOT compute divide-family ops while this block owns them; the EX mux selects result on result_valid.

Verification
REQ-030 DIVU 100/7 -> stall high cycles 0-32, result_valid in cycle 33, result=14; REMU -> 2.
REQ-031 DIV -20/3 -> quotient 32'hFFFF_FFFA (-6); REM -> 32'hFFFF_FFFE (-2).
REQ-032 DIV 5/0 -> result_valid in cycle 1, result=32'hFFFF_FFFF; REMU 5/0 -> 5.
REQ-033 DIV 32'h8000_0000/32'hFFFF_FFFF -> cycle 1, 32'h8000_0000; REM -> 0.
REQ-034 DIVU started, flush at cycle 10 -> cycle 11 IDLE, stall=0, no result_valid; subsequent ALU_ADD with start=1 -> not accepted.
REQ-035 reset_n low at cycle 15 of DIVU -> outputs zero immediately; after release no result_valid until new start.
